// File: rtl/uart_tx_seq.sv
// uart_tx_seq: buffered UART transmitter. A small FIFO accepts words on a
// valid/ready handshake; a framer serialises them as start, data (LSB first),
// optional parity and one or two stop bits, with an optional idle gap.
module uart_tx_seq #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CLKS     = 0,
  parameter int DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_BITS-1:0]         in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         txd,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_seq: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_seq: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_seq: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_seq: DEPTH must be a power of two, at least 2");
  end
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_seq: CLKS_PER_BIT must be in 2..65535");
  end
  if (GAP_CLKS < 0 || GAP_CLKS > 65535) begin : g_bad_gap
    $error("uart_tx_seq: GAP_CLKS must be in 0..65535");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_t;

  // Parity bit for a word: XOR of the data bits, inverted for odd parity.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~(^w) : (^w);
  endfunction

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [DATA_BITS-1:0]  shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [DATA_BITS-1:0]  head_word;
  logic                  push, pop, try_pop;

  assign in_ready   = ~reset && (level_q != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign head_word  = mem_q[rd_ptr_q];
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign level      = level_q;
  assign frame_done = frame_done_q;

  // Framer next state: per-bit baud countdown, bit sequencing and popping.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;
    try_pop = 1'b0;
    case (state_q)
      S_IDLE: try_pop = 1'b1;
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = shreg_q >> 1;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_PAR: begin
        if (baud_q == '0) begin
          state_d = S_STOP;
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          if (bit_q == LAST_STOP) begin
            if (GAP_CLKS > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_LOAD;
            end else begin
              try_pop = 1'b1;
            end
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            baud_d = BAUD_LOAD;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == '0) try_pop = 1'b1;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // A frame boundary starts the next word straight away if one is waiting.
    if (try_pop) begin
      if (level_q != '0) begin
        pop     = 1'b1;
        state_d = S_START;
        baud_d  = BAUD_LOAD;
        shreg_d = head_word;
        par_d   = parity_of(head_word);
      end else begin
        state_d = S_IDLE;
      end
    end
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_d[0];
      S_PAR:   txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
    frame_done_d = (state_d == S_STOP) && (baud_d == '0) && (bit_d == LAST_STOP);
  end

  // FIFO occupancy and the busy flag that depends on it.
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
    busy_d = !((state_d == S_IDLE) && (level_d == '0));
  end

  // Control state and registered outputs; reset drops the frame and flushes the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      gap_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      gap_q        <= gap_d;
      wr_ptr_q     <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_q     <= pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_q      <= level_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Datapath storage: FIFO array, shift register and latched parity bit.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: three instances (8E2 fast, 7O1 with gap, default 8N1
// at 217). Accepted words go into per-instance queues; a receiver-style
// monitor rebuilds each expected frame waveform from the frame format.
module tb_uart_tx_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] din [3];
  logic       vin [3];
  logic       rdy [3];
  logic       txd [3];
  logic       busy [3];
  logic [2:0] lvl [3];
  logic       fd [3];

  logic [8:0] expq [3][$];
  int         acc [3];
  int         started [3];
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  uart_tx_seq #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                .GAP_CLKS(0), .DEPTH(4)) u_a (
    .clk(clk), .reset(rst), .in_data(din[0][7:0]), .in_valid(vin[0]),
    .in_ready(rdy[0]), .txd(txd[0]), .busy(busy[0]), .level(lvl[0]),
    .frame_done(fd[0]));

  uart_tx_seq #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1),
                .GAP_CLKS(10), .DEPTH(4)) u_b (
    .clk(clk), .reset(rst), .in_data(din[1][6:0]), .in_valid(vin[1]),
    .in_ready(rdy[1]), .txd(txd[1]), .busy(busy[1]), .level(lvl[1]),
    .frame_done(fd[1]));

  uart_tx_seq u_c (
    .clk(clk), .reset(rst), .in_data(din[2][7:0]), .in_valid(vin[2]),
    .in_ready(rdy[2]), .txd(txd[2]), .busy(busy[2]), .level(lvl[2]),
    .frame_done(fd[2]));

  function automatic int cpb(input int k); return (k == 2) ? 217 : 4; endfunction
  function automatic int db(input int k);  return (k == 1) ? 7 : 8; endfunction
  function automatic int par(input int k); return (k == 0) ? 2 : ((k == 1) ? 1 : 0); endfunction
  function automatic int sb(input int k);  return (k == 0) ? 2 : 1; endfunction
  function automatic int gp(input int k);  return (k == 1) ? 10 : 0; endfunction
  function automatic logic [8:0] dmask(input int k); return (k == 1) ? 9'h07F : 9'h0FF; endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Offer one word; record it in the scoreboard on the edge it is accepted.
  task automatic send(input int k, input logic [8:0] w, input bit now);
    int  n;
    bit  done;
    int  model_lvl;
    if (!now) @(negedge clk);
    din[k] = w;
    vin[k] = 1'b1;
    n = 0;
    done = 0;
    while (!done) begin
      #4;
      model_lvl = acc[k] - started[k];
      chk($sformatf("level%0d", k), int'(lvl[k]), model_lvl);
      chk($sformatf("in_ready%0d", k), int'(rdy[k]), (model_lvl != 4) ? 1 : 0);
      if (rdy[k]) begin
        expq[k].push_back(w & dmask(k));
        acc[k]++;
        done = 1;
        @(posedge clk);
        #1;
      end else begin
        n++;
        if (n > 20000) begin
          chk($sformatf("send_timeout%0d", k), n, 0);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    vin[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy[k] == 1'b0 && expq[k].size() == 0) && n < 30000);
    chk($sformatf("idle_reached%0d", k), (n < 30000) ? 1 : 0, 1);
  endtask

  task automatic wait_fd(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fd[k] !== 1'b1 && n < 30000);
    chk($sformatf("frame_done_seen%0d", k), (n < 30000) ? 1 : 0, 1);
  endtask

  task automatic wait_start(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd[k] !== 1'b0 && n < 30000);
    chk($sformatf("start_seen%0d", k), (n < 30000) ? 1 : 0, 1);
  endtask

  // Serial-line monitor: checks every cycle of each frame against the frame format.
  task automatic mon(input int k);
    logic [8:0] w;
    logic       ebit [16];
    int         nbits, len, idle, bad_cyc;
    bit         have_prev, prev_nonempty, aborted, ok;
    logic       bad_txd, bad_fd;
    have_prev = 0;
    prev_nonempty = 0;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 0;
        idle = 0;
        continue;
      end
      if (txd[k] !== 1'b0) begin
        idle++;
        continue;
      end
      started[k]++;
      if (have_prev && prev_nonempty)
        chk($sformatf("gap_exact%0d", k), idle, gp(k));
      else if (have_prev && gp(k) > 0)
        chk($sformatf("gap_min%0d", k), (idle >= gp(k)) ? 1 : 0, 1);
      chk($sformatf("frame_expected%0d", k), (expq[k].size() != 0) ? 1 : 0, 1);
      w = (expq[k].size() != 0) ? expq[k].pop_front() : 9'h000;
      ebit[0] = 1'b0;
      for (int i = 0; i < db(k); i++) ebit[1 + i] = w[i];
      nbits = 1 + db(k);
      if (par(k) != 0) begin
        ebit[nbits] = (par(k) == 2) ? (^w) : ~(^w);
        nbits++;
      end
      for (int s = 0; s < sb(k); s++) begin
        ebit[nbits] = 1'b1;
        nbits++;
      end
      len = nbits * cpb(k);
      ok = 1;
      aborted = 0;
      bad_cyc = -1;
      bad_txd = 1'b0;
      bad_fd = 1'b0;
      for (int i = 0; i < len; i++) begin
        if (i > 0) @(negedge clk);
        if (rst) begin
          aborted = 1;
          break;
        end
        if (ok && (txd[k] !== ebit[i / cpb(k)] || fd[k] !== (i == len - 1) || busy[k] !== 1'b1)) begin
          ok = 0;
          bad_cyc = i;
          bad_txd = txd[k];
          bad_fd = fd[k];
        end
      end
      if (aborted) begin
        have_prev = 0;
        idle = 0;
        continue;
      end
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL frame%0d word 0x%0h: cycle %0d txd actual %0b required %0b, frame_done actual %0b required %0b",
                 k, w, bad_cyc, bad_txd, ebit[bad_cyc / cpb(k)], bad_fd, (bad_cyc == len - 1));
      end
      prev_nonempty = (expq[k].size() != 0);
      have_prev = 1;
      idle = 0;
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  initial begin
    #600000;
    $display("FAIL watchdog: actual timeout required finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [8:0] w;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0;
      vin[k] = 1'b0;
      acc[k] = 0;
      started[k] = 0;
    end
    #2 rst = 1'b1;
    #6;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_txd%0d", k), int'(txd[k]), 1);
      chk($sformatf("rst_in_ready%0d", k), int'(rdy[k]), 0);
      chk($sformatf("rst_busy%0d", k), int'(busy[k]), 0);
      chk($sformatf("rst_level%0d", k), int'(lvl[k]), 0);
      chk($sformatf("rst_frame_done%0d", k), int'(fd[k]), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_rst%0d", k), int'(rdy[k]), 1);

    // Default 8N1 at 217 clocks per bit, one word.
    send(2, 9'h036, 0);
    @(negedge clk);
    chk("c_txd_before_start", int'(txd[2]), 1);
    chk("c_busy_after_push", int'(busy[2]), 1);
    @(negedge clk);
    chk("c_txd_start", int'(txd[2]), 0);
    wait_fd(2, n);
    chk("c_frame_len", n + 1, 2170);
    @(negedge clk);
    chk("c_busy_after_frame", int'(busy[2]), 0);
    chk("c_level_after_frame", int'(lvl[2]), 0);

    // Parity bit values.
    send(0, 9'h02A, 0); wait_start(0); repeat (37) @(negedge clk);
    chk("a_even_par_2A", int'(txd[0]), 1); wait_idle(0);
    send(0, 9'h036, 0); wait_start(0); repeat (37) @(negedge clk);
    chk("a_even_par_36", int'(txd[0]), 0); wait_idle(0);
    send(1, 9'h02A, 0); wait_start(1); repeat (33) @(negedge clk);
    chk("b_odd_par_2A", int'(txd[1]), 0); wait_idle(1);
    send(1, 9'h036, 0); wait_start(1); repeat (33) @(negedge clk);
    chk("b_odd_par_36", int'(txd[1]), 1); wait_idle(1);

    // Six words held back-to-back through a four-deep FIFO.
    send(0, 9'h036, 0); send(0, 9'h02A, 0); send(0, 9'h039, 0);
    send(0, 9'h039, 0); send(0, 9'h02F, 0); send(0, 9'h033, 0);
    wait_idle(0);
    chk("a_level_drained", int'(lvl[0]), 0);

    // Two words through the gapped 7-bit instance.
    send(1, 9'h055, 0); send(1, 9'h02B, 0);
    wait_idle(1);

    // Push on the pop edge with three queued, then offer while full.
    send(0, 9'h011, 0); send(0, 9'h022, 0); send(0, 9'h044, 0); send(0, 9'h088, 0);
    wait_fd(0, n);
    send(0, 9'h0F0, 1);
    @(negedge clk);
    chk("a_level_push_on_pop", int'(lvl[0]), 3);
    send(0, 9'h00F, 0);
    @(negedge clk);
    din[0] = 9'h0AA;
    vin[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("a_full_in_ready", int'(rdy[0]), 0);
      chk("a_full_level", int'(lvl[0]), 4);
      @(negedge clk);
    end
    vin[0] = 1'b0;
    wait_idle(0);

    // Random traffic on both fast instances.
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
          w = 9'($urandom) & dmask(0);
          send(0, w, 0);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
          send(1, 9'($urandom) & dmask(1), 0);
        end
      end
    join
    wait_idle(0);
    wait_idle(1);

    // Reset in the middle of the second frame's data bits.
    send(0, 9'h02A, 0); send(0, 9'h036, 0); send(0, 9'h039, 0);
    wait_fd(0, n);
    repeat (17) @(negedge clk);
    chk("a_txd_low_before_rst", int'(txd[0]), 0);
    #2 rst = 1'b1;
    #1;
    chk("a_txd_async_rst", int'(txd[0]), 1);
    chk("a_level_async_rst", int'(lvl[0]), 0);
    chk("a_busy_async_rst", int'(busy[0]), 0);
    chk("a_ready_async_rst", int'(rdy[0]), 0);
    for (int k = 0; k < 3; k++) begin
      expq[k].delete();
      acc[k] = 0;
      started[k] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("a_ready_after_rst", int'(rdy[0]), 1);
    send(0, 9'h055, 0);
    wait_idle(0);
    chk("a_busy_final", int'(busy[0]), 0);

    for (int k = 0; k < 3; k++) chk($sformatf("queue_empty%0d", k), expq[k].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
